// File: rtl/cp3_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// cp3_access_arbiter_if
//   Bundles every request/response, CP3-side and status signal of the CP3
//   access arbiter so the arbiter and its environment connect through one port.
//   Core side : core_req_valid/ready/inst/wdata, core_rsp_valid/data/err
//   Host side : host_req_valid/ready/addr/write/wdata, host_rsp_valid/data/err
//   CP3 side  : cp_enable, cp_instruction, cp_data_in, cp_data_out, cp_ready,
//               cp_exception
//   Status    : core_halted (input), grant_host, busy (outputs)
//   Modports  : slave  = the arbiter itself
//               master = the surrounding system (core, debug host, CP3)
// ---------------------------------------------------------------------------
interface cp3_access_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  core_req_valid;
    logic                  core_req_ready;
    logic [INST_WIDTH-1:0] core_req_inst;
    logic [DATA_WIDTH-1:0] core_req_wdata;
    logic                  core_rsp_valid;
    logic [DATA_WIDTH-1:0] core_rsp_data;
    logic                  core_rsp_err;

    logic                  host_req_valid;
    logic                  host_req_ready;
    logic [11:0]           host_req_addr;
    logic                  host_req_write;
    logic [DATA_WIDTH-1:0] host_req_wdata;
    logic                  host_rsp_valid;
    logic [DATA_WIDTH-1:0] host_rsp_data;
    logic                  host_rsp_err;

    logic                  core_halted;

    logic                  cp_enable;
    logic [INST_WIDTH-1:0] cp_instruction;
    logic [DATA_WIDTH-1:0] cp_data_in;
    logic [DATA_WIDTH-1:0] cp_data_out;
    logic                  cp_ready;
    logic                  cp_exception;

    logic                  grant_host;
    logic                  busy;

    modport slave (
        input  core_req_valid, core_req_inst, core_req_wdata,
        output core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_err,
        input  host_req_valid, host_req_addr, host_req_write, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        input  core_halted,
        output cp_enable, cp_instruction, cp_data_in,
        input  cp_data_out, cp_ready, cp_exception,
        output grant_host, busy
    );

    modport master (
        output core_req_valid, core_req_inst, core_req_wdata,
        input  core_req_ready, core_rsp_valid, core_rsp_data, core_rsp_err,
        output host_req_valid, host_req_addr, host_req_write, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_data, host_rsp_err,
        output core_halted,
        input  cp_enable, cp_instruction, cp_data_in,
        output cp_data_out, cp_ready, cp_exception,
        input  grant_host, busy
    );
endinterface

// File: rtl/cp3_access_arbiter.sv
// ---------------------------------------------------------------------------
// cp3_access_arbiter
//   Shares the single CP3 (debug coprocessor) CSR port between the core
//   pipeline and the external debug host. One transaction at a time:
//   arbitrate in IDLE, drive CP3 in ISSUE, answer the owner in RESP.
//   Ports:
//     clk   - clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - cp3_access_arbiter_if.slave (requests, responses, CP3 port,
//             core_halted, grant_host, busy)
//   Parameters: DATA_WIDTH, INST_WIDTH, TIMEOUT_CYCLES (ISSUE cycles allowed
//   without cp_ready before an error response, must be >= 1).
// ---------------------------------------------------------------------------
module cp3_access_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int INST_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cp3_access_arbiter_if.slave    bus
);
    localparam int         CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e                state_q, state_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] core_rsp_data_q, core_rsp_data_d;
    logic                  core_rsp_err_q, core_rsp_err_d;
    logic [DATA_WIDTH-1:0] host_rsp_data_q, host_rsp_data_d;
    logic                  host_rsp_err_q, host_rsp_err_d;

    logic                  host_wins;
    logic                  core_accept;
    logic                  host_accept;
    logic                  core_legal;
    logic                  issue_timeout;
    logic [INST_WIDTH-1:0] host_inst;

    // Host wins when it is alone, when the core is halted, or when the
    // core owned the previous transaction (round-robin on a tie).
    assign host_wins   = bus.host_req_valid &&
                         (!bus.core_req_valid || bus.core_halted || !last_owner_q);
    assign host_accept = (state_q == IDLE) && host_wins;
    assign core_accept = (state_q == IDLE) && bus.core_req_valid && !host_wins;

    // Only SYSTEM-opcode CSRRW/CSRRS/CSRRC may reach CP3.
    assign core_legal = (bus.core_req_inst[6:0] == OPC_SYSTEM) &&
                        (bus.core_req_inst[14:12] inside {3'b001, 3'b010, 3'b011});

    // Host reads become CSRRS with rs1=x0, writes become CSRRW; rd is x0.
    assign host_inst = INST_WIDTH'({bus.host_req_addr, 5'd0,
                                    (bus.host_req_write ? 3'b001 : 3'b010),
                                    5'd0, OPC_SYSTEM});

    // The final permitted ISSUE cycle has elapsed without an answer.
    assign issue_timeout = !bus.cp_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers. last_owner resets to host so the core wins the
    // first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q          <= '0;
            wdata_q         <= '0;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            cnt_q           <= '0;
            core_rsp_data_q <= '0;
            core_rsp_err_q  <= 1'b0;
            host_rsp_data_q <= '0;
            host_rsp_err_q  <= 1'b0;
        end else begin
            inst_q          <= inst_d;
            wdata_q         <= wdata_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            cnt_q           <= cnt_d;
            core_rsp_data_q <= core_rsp_data_d;
            core_rsp_err_q  <= core_rsp_err_d;
            host_rsp_data_q <= host_rsp_data_d;
            host_rsp_err_q  <= host_rsp_err_d;
        end
    end

    // Next-state logic. Illegal core requests skip ISSUE entirely.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (host_accept) begin
                    state_d = ISSUE;
                end else if (core_accept) begin
                    state_d = core_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (bus.cp_ready || issue_timeout) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch the request on accept, and load the
    // owner's response registers on the cycle that moves into RESP so the
    // data is presented with rsp_valid and then held afterwards.
    always_comb begin
        inst_d          = inst_q;
        wdata_d         = wdata_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        cnt_d           = cnt_q;
        core_rsp_data_d = core_rsp_data_q;
        core_rsp_err_d  = core_rsp_err_q;
        host_rsp_data_d = host_rsp_data_q;
        host_rsp_err_d  = host_rsp_err_q;

        if (host_accept) begin
            inst_d       = host_inst;
            wdata_d      = bus.host_req_wdata;
            owner_d      = 1'b1;
            last_owner_d = 1'b1;
            cnt_d        = '0;
        end else if (core_accept) begin
            inst_d       = bus.core_req_inst;
            wdata_d      = bus.core_req_wdata;
            owner_d      = 1'b0;
            last_owner_d = 1'b0;
            cnt_d        = '0;
            if (!core_legal) begin
                core_rsp_data_d = '0;
                core_rsp_err_d  = 1'b1;
            end
        end

        if (state_q == ISSUE) begin
            if (bus.cp_ready) begin
                if (owner_q) begin
                    host_rsp_data_d = bus.cp_data_out;
                    host_rsp_err_d  = bus.cp_exception;
                end else begin
                    core_rsp_data_d = bus.cp_data_out;
                    core_rsp_err_d  = bus.cp_exception;
                end
            end else if (issue_timeout) begin
                if (owner_q) begin
                    host_rsp_data_d = '0;
                    host_rsp_err_d  = 1'b1;
                end else begin
                    core_rsp_data_d = '0;
                    core_rsp_err_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs. The CP3 port is quiet (all zero) outside ISSUE, and only the
    // owner ever sees rsp_valid.
    always_comb begin
        bus.core_req_ready = core_accept;
        bus.host_req_ready = host_accept;
        bus.core_rsp_valid = (state_q == RESP) && !owner_q;
        bus.host_rsp_valid = (state_q == RESP) && owner_q;
        bus.core_rsp_data  = core_rsp_data_q;
        bus.core_rsp_err   = core_rsp_err_q;
        bus.host_rsp_data  = host_rsp_data_q;
        bus.host_rsp_err   = host_rsp_err_q;
        bus.cp_enable      = 1'b0;
        bus.cp_instruction = '0;
        bus.cp_data_in     = '0;
        if (state_q == ISSUE) begin
            bus.cp_enable      = 1'b1;
            bus.cp_instruction = inst_q;
            bus.cp_data_in     = wdata_q;
        end
        bus.grant_host = owner_q;
        bus.busy       = (state_q != IDLE);
    end
endmodule

// File: tb/tb_cp3_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cp3_access_arbiter
//   Self-checking bench for cp3_access_arbiter: directed scenarios followed by
//   randomized transactions, compared against a transaction-level model of
//   the arbitration, encoding, latency and response rules.
// ---------------------------------------------------------------------------
module tb_cp3_access_arbiter;
    localparam int DW  = 64;
    localparam int IW  = 32;
    localparam int TMO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    cp3_access_arbiter_if #(.DATA_WIDTH(DW), .INST_WIDTH(IW)) bus ();

    cp3_access_arbiter #(
        .DATA_WIDTH(DW), .INST_WIDTH(IW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: who owned the last transaction and what each
    // requester's held response currently is.
    bit            mLastHost;
    bit            mGrantHost;
    logic [DW-1:0] mCoreData, mHostData;
    bit            mCoreErr, mHostErr;

    task automatic resetModel();
        mLastHost  = 1'b1;
        mGrantHost = 1'b0;
        mCoreData  = '0;
        mHostData  = '0;
        mCoreErr   = 1'b0;
        mHostErr   = 1'b0;
    endtask

    // One comparison: counts it and reports a FAIL line if it disagrees.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkCpQuiet(input string tag);
        checkOutput({tag, ".cpEnable"}, 64'(bus.cp_enable), 64'd0);
        checkOutput({tag, ".cpInst"},   64'(bus.cp_instruction), 64'd0);
        checkOutput({tag, ".cpDataIn"}, bus.cp_data_in, 64'd0);
    endtask

    task automatic checkRsp(input string tag, input bit expCore, input bit expHost);
        checkOutput({tag, ".coreRspValid"}, 64'(bus.core_rsp_valid), 64'(expCore));
        checkOutput({tag, ".hostRspValid"}, 64'(bus.host_rsp_valid), 64'(expHost));
        checkOutput({tag, ".coreRspData"},  bus.core_rsp_data, mCoreData);
        checkOutput({tag, ".coreRspErr"},   64'(bus.core_rsp_err), 64'(mCoreErr));
        checkOutput({tag, ".hostRspData"},  bus.host_rsp_data, mHostData);
        checkOutput({tag, ".hostRspErr"},   64'(bus.host_rsp_err), 64'(mHostErr));
    endtask

    // Arbitration rule: lone requester wins; on a tie the host wins while
    // halted, otherwise whichever requester did not own the last transaction.
    function automatic bit predictHostWins(bit cv, bit hv, bit halted, bit lastHost);
        if (!hv)     return 1'b0;
        if (!cv)     return 1'b1;
        if (halted)  return 1'b1;
        return (lastHost == 1'b0);
    endfunction

    function automatic bit coreIsLegal(logic [31:0] inst);
        int f3;
        f3 = int'((inst >> 12) & 32'h7);
        return ((inst & 32'h7f) == 32'h73) && (f3 >= 1) && (f3 <= 3);
    endfunction

    function automatic logic [31:0] hostEncoding(logic [11:0] addr, bit wr);
        return (32'(addr) << 20) | ((wr ? 32'd1 : 32'd2) << 12) | 32'h73;
    endfunction

    task automatic applyStimulus(input bit cv, input logic [31:0] cinst, input logic [63:0] cwd,
                                 input bit hv, input logic [11:0] addr, input bit hw,
                                 input logic [63:0] hwd, input bit halted);
        bus.core_req_valid = cv;
        bus.core_req_inst  = cinst;
        bus.core_req_wdata = cwd;
        bus.host_req_valid = hv;
        bus.host_req_addr  = addr;
        bus.host_req_write = hw;
        bus.host_req_wdata = hwd;
        bus.core_halted    = halted;
    endtask

    // Runs one transaction starting at a negedge in IDLE with requests
    // already applied, and returns at the negedge of the next IDLE cycle.
    // readyDelay >= TMO means CP3 never answers. resetAt >= 0 pulses rst_n
    // in that ISSUE cycle. fixedInst (when nonzero) is a literal expected
    // CP3 instruction on top of the model's own encoding.
    task automatic runTxn(input string tag, input int readyDelay, input logic [63:0] cpData,
                          input bit exc, input bit churnHalted, input int resetAt,
                          input logic [31:0] fixedInst);
        bit hostWon, anyWon, done;
        logic [31:0] expInst;
        logic [63:0] expWd;
        bus.cp_ready     = 1'b0;
        bus.cp_exception = 1'b0;
        bus.cp_data_out  = '0;
        #1;
        hostWon = predictHostWins(bus.core_req_valid, bus.host_req_valid,
                                  bus.core_halted, mLastHost);
        anyWon  = bus.core_req_valid || bus.host_req_valid;
        checkOutput({tag, ".idleBusy"},  64'(bus.busy), 64'd0);
        checkOutput({tag, ".coreReady"}, 64'(bus.core_req_ready), 64'(anyWon && !hostWon));
        checkOutput({tag, ".hostReady"}, 64'(bus.host_req_ready), 64'(hostWon));
        checkCpQuiet({tag, ".idle"});
        checkRsp({tag, ".idle"}, 1'b0, 1'b0);
        @(negedge clk);
        if (!anyWon) return;

        mLastHost  = hostWon;
        mGrantHost = hostWon;
        expInst = hostWon ? hostEncoding(bus.host_req_addr, bus.host_req_write) : bus.core_req_inst;
        expWd   = hostWon ? bus.host_req_wdata : bus.core_req_wdata;

        if (!hostWon && !coreIsLegal(bus.core_req_inst)) begin
            mCoreData = '0;
            mCoreErr  = 1'b1;
            checkRsp({tag, ".illegal"}, 1'b1, 1'b0);
            checkCpQuiet({tag, ".illegal"});
            checkOutput({tag, ".grantHost"}, 64'(bus.grant_host), 64'(mGrantHost));
            @(negedge clk);
            return;
        end

        done = 1'b0;
        for (int k = 0; k < TMO && !done; k++) begin
            if (churnHalted) bus.core_halted = 1'($urandom_range(0, 1));
            if (k == resetAt) begin
                rst_n = 1'b0;
                #1;
                resetModel();
                checkCpQuiet({tag, ".inReset"});
                checkOutput({tag, ".resetBusy"},  64'(bus.busy), 64'd0);
                checkOutput({tag, ".resetGrant"}, 64'(bus.grant_host), 64'd0);
                checkRsp({tag, ".inReset"}, 1'b0, 1'b0);
                bus.core_req_valid = 1'b0;
                bus.host_req_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checkOutput({tag, ".afterResetBusy"}, 64'(bus.busy), 64'd0);
                checkRsp({tag, ".afterReset"}, 1'b0, 1'b0);
                return;
            end
            bus.cp_ready     = (k == readyDelay);
            bus.cp_data_out  = cpData;
            bus.cp_exception = exc;
            #1;
            checkOutput({tag, ".cpEnable"},  64'(bus.cp_enable), 64'd1);
            checkOutput({tag, ".cpInst"},    64'(bus.cp_instruction), 64'(expInst));
            if (fixedInst != 32'd0)
                checkOutput({tag, ".cpInstLit"}, 64'(bus.cp_instruction), 64'(fixedInst));
            checkOutput({tag, ".cpDataIn"},  bus.cp_data_in, expWd);
            checkOutput({tag, ".issueBusy"}, 64'(bus.busy), 64'd1);
            checkOutput({tag, ".issueCoreReady"}, 64'(bus.core_req_ready), 64'd0);
            checkOutput({tag, ".issueHostReady"}, 64'(bus.host_req_ready), 64'd0);
            checkOutput({tag, ".grantHost"}, 64'(bus.grant_host), 64'(mGrantHost));
            checkRsp({tag, ".issue"}, 1'b0, 1'b0);
            if (k == readyDelay || k == TMO - 1) begin
                done = 1'b1;
                if (hostWon) begin
                    mHostData = (k == readyDelay) ? cpData : '0;
                    mHostErr  = (k == readyDelay) ? exc : 1'b1;
                end else begin
                    mCoreData = (k == readyDelay) ? cpData : '0;
                    mCoreErr  = (k == readyDelay) ? exc : 1'b1;
                end
            end
            @(negedge clk);
        end
        bus.cp_ready = 1'b0;
        checkRsp({tag, ".resp"}, !hostWon, hostWon);
        checkCpQuiet({tag, ".resp"});
        checkOutput({tag, ".respBusy"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
    endtask

    // Directed scenarios, then randomized traffic, then the summary line.
    initial begin
        resetModel();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        bus.cp_data_out  = '0;
        bus.cp_ready     = 1'b0;
        bus.cp_exception = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset.busy",  64'(bus.busy), 64'd0);
        checkOutput("reset.grant", 64'(bus.grant_host), 64'd0);
        checkCpQuiet("reset");
        checkRsp("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] host read 0x001");
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h001, 1'b0, 64'h0, 1'b0);
        runTxn("hostRead", 0, 64'h20, 1'b0, 1'b0, -1, 32'h00102073);
        checkOutput("hostRead.data", bus.host_rsp_data, 64'h20);

        $display("[TB] host write 0x020");
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h020, 1'b1, 64'h8000_1000, 1'b0);
        runTxn("hostWrite", 0, 64'h5, 1'b0, 1'b0, -1, 32'h02001073);

        $display("[TB] round robin, both valid");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        applyStimulus(1'b1, 32'h3000_2073, 64'h11, 1'b1, 12'h7b0, 1'b0, 64'h22, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runTxn("roundRobin", 0, 64'(100 + i), 1'b0, 1'b0, -1, 32'd0);
            checkOutput("roundRobin.order", 64'(bus.grant_host), 64'(i % 2));
        end

        $display("[TB] host priority while halted");
        applyStimulus(1'b1, 32'h3000_1073, 64'h33, 1'b1, 12'h7b1, 1'b1, 64'h44, 1'b1);
        for (int i = 0; i < 3; i++) begin
            runTxn("halted", 0, 64'(200 + i), 1'b0, 1'b0, -1, 32'd0);
            checkOutput("halted.order", 64'(bus.grant_host), 64'd1);
        end

        $display("[TB] illegal core instruction");
        applyStimulus(1'b1, 32'h0000_0013, 64'h55, 1'b0, '0, 1'b0, '0, 1'b0);
        runTxn("illegal", 0, 64'hdead, 1'b0, 1'b0, -1, 32'd0);
        checkOutput("illegal.err", 64'(bus.core_rsp_err), 64'd1);

        $display("[TB] timeout and reset mid-ISSUE");
        applyStimulus(1'b1, 32'h7b00_2073, 64'h66, 1'b0, '0, 1'b0, '0, 1'b0);
        runTxn("timeout", TMO + 5, 64'hbeef, 1'b0, 1'b0, -1, 32'd0);
        checkOutput("timeout.err", 64'(bus.core_rsp_err), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h7b2, 1'b1, 64'h77, 1'b0);
        runTxn("resetMid", TMO + 5, 64'h0, 1'b0, 1'b0, 3, 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h7b3, 1'b0, 64'h0, 1'b0);
        runTxn("afterReset", 1, 64'h1234, 1'b1, 1'b0, -1, 32'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 80; i++) begin
            logic [31:0] inst;
            int          r;
            int          delay;
            inst = $urandom;
            if ($urandom_range(0, 3) != 0) inst = (inst & ~32'h7f) | 32'h73;
            r     = $urandom_range(0, 9);
            delay = (r < 8) ? (r % 3) : (TMO + 2);
            applyStimulus(1'($urandom_range(0, 1)), inst, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            runTxn("random", delay, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   1'b1, -1, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
